fmap_relay: RTL and testbench
=============================

Name: fmap_relay

Overview:
- Sits between two conv_mix stages and forms the return path of the conv_mix din/din_ready interface.
- Consumes the upstream stage's pooled output stream (ovalid/dout) and buffers one full feature map.
- Raises the downstream stage's start, then replays the map pixel-by-pixel on din while the downstream stage holds din_ready.
- Turns the layer-0 output (12x12 = 144 pixels) into the layer-1 input.

Parameters:
DATA_W, 32, pixel width (signed, two's complement)
DEPTH, 144, pixels per feature map
AW, 8, address/counter width; must satisfy 2**AW >= DEPTH+1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream pixel strobe (upstream ovalid)
in_data  in  DATA_W  upstream pixel (upstream dout)
out_start  out  1  level start to downstream conv_mix
out_ready  in  1  downstream din_ready; a pixel is consumed every cycle it is high
out_data  out  DATA_W  pixel to downstream din
next_done  in  1  downstream done; releases the buffer
busy  out  1  high in any state except IDLE
overflow  out  1  sticky: a pixel arrived while the buffer could not accept it

Behaviour:
- Reset (async, immediate): state=IDLE, wr_cnt=0, rd_ptr=0, out_start=0, out_data=0, busy=0, overflow=0. Buffer contents are don't-care.
- Storage: DEPTH x DATA_W register file. Synchronous write; read is combinational from rd_ptr, so out_data is valid in the same cycle out_ready is high.
- IDLE:
  - in_valid writes mem[0], sets wr_cnt=1, moves to FILL.
  - DEPTH=1 goes straight to FULL.
- FILL:
  - Each in_valid writes mem[wr_cnt] and increments wr_cnt. Gaps in in_valid are allowed.
  - The write that makes wr_cnt==DEPTH moves to FULL on the next edge.
- FULL:
  - out_start=1 from the first FULL cycle; it stays high until the state returns to IDLE.
  - First cycle with out_ready=1 moves to DRAIN and counts as consumption of mem[0].
- DRAIN:
  - out_data = mem[rd_ptr] while rd_ptr<DEPTH, otherwise 0 (trailing pad).
  - rd_ptr increments every out_ready=1 cycle and saturates at DEPTH.
  - out_ready dropping mid-drain freezes rd_ptr; out_data holds its value.
- next_done=1 in DRAIN or FULL: go to IDLE on the next edge; out_start=0, rd_ptr=0, wr_cnt=0.
- next_done in IDLE/FILL: ignored.
- in_valid in FULL or DRAIN: pixel dropped, overflow<=1. overflow clears only on rst.
- in_valid on the same cycle as the next_done exit: pixel dropped, overflow set. No write to the new frame.
- out_data when not in DRAIN/FULL: 0.
- In FULL, out_data = mem[0].
- rst asserted mid-fill or mid-drain: everything returns to reset values within the same cycle; no partial state survives.

Decomposition:
- Shared package: state encoding (IDLE=0, FILL=1, FULL=2, DRAIN=3), DATA_W default, and layer pixel constants L0_FMAP=144, L1_FMAP=16.
- One natural sub-module, fmap_regfile: 1 write port, 1 async read port, DEPTH x DATA_W.
- The FSM and counters live in fmap_relay.

Test Plan:
- Fill, then drain: 144 in_valid pulses with data=1..144, out_ready held high from the first FULL cycle.
  - out_start rises the cycle after the 144th write.
  - out_data sequence 1..144, then 0 pad.
  - next_done pulse -> IDLE, out_start=0 the next cycle, busy=0.
- Bursty input: in_valid 1-on/2-off for 144 pixels (values -5, 7, -5, 7, ...).
  - Stored order is preserved; signed values are replayed bit-exact (0xFFFFFFFB, 0x00000007).
- Stalled drain: out_ready toggled 1,0,0,1 during DRAIN.
  - rd_ptr advances only on high cycles; out_data is stable during stalls.
  - No pixel is skipped or duplicated across 144 consumptions.
- Overflow: 145th in_valid (data=0xDEAD) while in FULL.
  - overflow=1 and stays high.
  - The drained sequence contains no 0xDEAD.
  - out_data[143] equals the 144th written value.
- Async reset mid-drain: rst pulsed for less than one clock period, between edges, at rd_ptr=70.
  - out_start, busy and out_data are 0 immediately.
  - The next fill starts at mem[0] and replays correctly.
- DEPTH=16 instance (layer-1 map), with next_done arriving in FULL before any out_ready.
  - Immediate return to IDLE.
  - A subsequent fill of 16 works normally.

Source files
------------

// File: rtl/fmap_relay_pkg.sv
// Shared definitions for the feature-map relay between two conv_mix stages:
// FSM state encoding, default pixel width and per-layer map sizes.
package fmap_relay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } relay_state_t;

    localparam int DATA_W_DEF = 32;
    localparam int L0_FMAP    = 144;
    localparam int L1_FMAP    = 16;

    // Index width needed to address a storage array of the given depth.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fmap_regfile.sv
// One-map pixel store: single synchronous write port and one combinational
// read port. Reads past the last entry return zero, which the relay uses as
// its trailing pad.
module fmap_regfile
    import fmap_relay_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = L0_FMAP,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int            IW      = addr_w(DEPTH);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming pixel; out-of-range addresses are ignored.
    always_ff @(posedge clk) begin
        if (we && (waddr < DEPTH_A)) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Combinational read so the pixel is available in the cycle it is consumed.
    assign rdata = (raddr < DEPTH_A) ? mem[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/fmap_relay.sv
// Buffers one complete feature map from the upstream conv_mix pooled output,
// then starts the downstream stage and replays the map on its din port,
// one pixel per cycle of din_ready.
module fmap_relay
    import fmap_relay_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = L0_FMAP,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_start,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              next_done,
    output logic              busy,
    output logic              overflow
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    relay_state_t      state, state_next;
    logic [AW-1:0]     wr_cnt, wr_cnt_next;
    logic [AW-1:0]     rd_ptr, rd_ptr_next;
    logic              overflow_next;
    logic              we;
    logic [AW-1:0]     wr_inc;
    logic [DATA_W-1:0] rdata;

    fmap_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (wr_cnt),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Write count after the current pixel lands.
    assign wr_inc = wr_cnt + AW'(1);

    // Next-state, counter and write-enable logic; a done from downstream
    // always wins over consumption so the buffer is released promptly.
    always_comb begin
        state_next    = state;
        wr_cnt_next   = wr_cnt;
        rd_ptr_next   = rd_ptr;
        overflow_next = overflow;
        we            = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    we          = 1'b1;
                    wr_cnt_next = AW'(1);
                    state_next  = (DEPTH == 1) ? ST_FULL : ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    we          = 1'b1;
                    wr_cnt_next = wr_inc;
                    if (wr_inc == DEPTH_A) begin
                        state_next = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (in_valid) begin
                    overflow_next = 1'b1;
                end
                if (next_done) begin
                    state_next  = ST_IDLE;
                    wr_cnt_next = '0;
                    rd_ptr_next = '0;
                end else if (out_ready) begin
                    state_next  = ST_DRAIN;
                    rd_ptr_next = AW'(1);
                end
            end
            ST_DRAIN: begin
                if (in_valid) begin
                    overflow_next = 1'b1;
                end
                if (next_done) begin
                    state_next  = ST_IDLE;
                    wr_cnt_next = '0;
                    rd_ptr_next = '0;
                end else if (out_ready && (rd_ptr != DEPTH_A)) begin
                    rd_ptr_next = rd_ptr + AW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters and the sticky overflow flag; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            wr_cnt   <= wr_cnt_next;
            rd_ptr   <= rd_ptr_next;
            overflow <= overflow_next;
        end
    end

    // Start stays up for the whole time a complete map is held.
    assign out_start = (state == ST_FULL) || (state == ST_DRAIN);
    assign busy      = (state != ST_IDLE);
    assign out_data  = out_start ? rdata : '0;

endmodule

// File: tb/tb_fmap_relay.sv
// Scoreboard bench for fmap_relay: a layer-0 instance (144 pixels) and a
// layer-1 instance (16 pixels), driven with directed frames.
module tb_fmap_relay;
    import fmap_relay_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_valid  = '0;
    logic [1:0]  out_ready = '0;
    logic [1:0]  next_done = '0;
    logic [31:0] in_data [2] = '{32'd0, 32'd0};
    logic [1:0]  out_start;
    logic [1:0]  busy;
    logic [1:0]  overflow;
    logic [31:0] out_data [2];

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fmap_relay #(.DATA_W(32), .DEPTH(L0_FMAP), .AW(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_data   (in_data[0]),
        .out_start (out_start[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .next_done (next_done[0]),
        .busy      (busy[0]),
        .overflow  (overflow[0])
    );

    fmap_relay #(.DATA_W(32), .DEPTH(L1_FMAP), .AW(5)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_data   (in_data[1]),
        .out_start (out_start[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .next_done (next_done[1]),
        .busy      (busy[1]),
        .overflow  (overflow[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    // One clock of stimulus on instance b; valid and done are single-cycle pulses.
    task automatic applyStimulus(input int b, input logic v, input logic [31:0] d, input logic r, input logic dn);
        in_valid[b]  = v;
        in_data[b]   = d;
        out_ready[b] = r;
        next_done[b] = dn;
        @(posedge clk);
        #1;
        in_valid[b]  = 1'b0;
        next_done[b] = 1'b0;
    endtask

    // mode 0: values base+1..base+n back to back; mode 1: -5/7 alternating, 1-on/2-off.
    task automatic fill(input int b, input int n, input int mode, input logic [31:0] base);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            if (mode == 1) v = (i % 2 == 0) ? 32'hFFFF_FFFB : 32'h0000_0007;
            else           v = base + 32'(i) + 32'd1;
            if (b == 0) exp_q0.push_back(v);
            else        exp_q1.push_back(v);
            applyStimulus(b, 1'b1, v, 1'b0, 1'b0);
            if (mode == 1) begin
                applyStimulus(b, 1'b0, 32'd0, 1'b0, 1'b0);
                applyStimulus(b, 1'b0, 32'd0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic drain(input int b, input int n_data, input int n_pad);
        for (int i = 0; i < n_pad; i++) begin
            if (b == 0) exp_q0.push_back(32'd0);
            else        exp_q1.push_back(32'd0);
        end
        for (int i = 0; i < n_data + n_pad; i++) begin
            applyStimulus(b, 1'b0, 32'd0, 1'b1, 1'b0);
        end
        out_ready[b] = 1'b0;
    endtask

    task automatic finishFrame(input int b, input string tag);
        applyStimulus(b, 1'b0, 32'd0, 1'b0, 1'b1);
        checkBit({tag, "_busy_after_done"}, busy[b], 1'b0);
        checkBit({tag, "_start_after_done"}, out_start[b], 1'b0);
        checkOutput({tag, "_data_after_done"}, out_data[b], 32'd0);
    endtask

    // Monitor for the 144-pixel instance: pop on every consumption, and
    // during stalls the held pixel must be the next one still owed.
    always @(negedge clk) begin
        if (!rst && out_start[0]) begin
            if (out_ready[0]) begin
                if (exp_q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL drain_extra_a: got 0x%08h, wanted no consumption", out_data[0]);
                end else begin
                    checkOutput("drain_a", out_data[0], exp_q0.pop_front());
                end
            end else if (exp_q0.size() != 0) begin
                checkOutput("stall_a", out_data[0], exp_q0[0]);
            end
        end
    end

    // Monitor for the 16-pixel instance.
    always @(negedge clk) begin
        if (!rst && out_start[1]) begin
            if (out_ready[1]) begin
                if (exp_q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL drain_extra_b: got 0x%08h, wanted no consumption", out_data[1]);
                end else begin
                    checkOutput("drain_b", out_data[1], exp_q1.pop_front());
                end
            end else if (exp_q1.size() != 0) begin
                checkOutput("stall_b", out_data[1], exp_q1[0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int highs;
        int k;
        logic r;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkBit("rst_start_a", out_start[0], 1'b0);
        checkBit("rst_busy_a", busy[0], 1'b0);
        checkBit("rst_ovf_a", overflow[0], 1'b0);
        checkOutput("rst_data_a", out_data[0], 32'd0);
        checkBit("rst_busy_b", busy[1], 1'b0);
        checkOutput("rst_data_b", out_data[1], 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain fill 1..144, start timing, full drain with two pad cycles
        fill(0, 143, 0, 32'd0);
        checkBit("start_before_last", out_start[0], 1'b0);
        checkBit("busy_filling", busy[0], 1'b1);
        fill(0, 1, 0, 32'd143);
        checkBit("start_after_last", out_start[0], 1'b1);
        checkOutput("full_shows_first", out_data[0], 32'd1);
        drain(0, 144, 2);
        checkOutput("queue_empty_t1", exp_q0.size(), 32'd0);
        finishFrame(0, "t1");

        // Overflow in FULL plus a pixel on the exit cycle
        fill(0, 144, 0, 32'd1000);
        checkBit("ovf_clear_before", overflow[0], 1'b0);
        applyStimulus(0, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
        checkBit("ovf_set", overflow[0], 1'b1);
        drain(0, 144, 1);
        checkOutput("queue_empty_t2", exp_q0.size(), 32'd0);
        checkBit("ovf_sticky_drain", overflow[0], 1'b1);
        applyStimulus(0, 1'b1, 32'h0000_BEEF, 1'b0, 1'b1);
        checkBit("busy_after_exit", busy[0], 1'b0);

        // Bursty signed fill, drain with 1,0,0,1 ready pattern
        fill(0, 144, 1, 32'd0);
        checkBit("ovf_sticky_idle", overflow[0], 1'b1);
        checkOutput("signed_first", out_data[0], 32'hFFFF_FFFB);
        highs = 0;
        k = 0;
        while (highs < 144 && k < 1000) begin
            r = (k % 4 == 0) || (k % 4 == 3);
            applyStimulus(0, 1'b0, 32'd0, r, 1'b0);
            if (r) highs++;
            k++;
        end
        out_ready[0] = 1'b0;
        checkOutput("queue_empty_t3", exp_q0.size(), 32'd0);
        finishFrame(0, "t3");

        // Async reset pulse between edges mid-drain
        fill(0, 144, 0, 32'd200);
        drain(0, 70, 0);
        #2;
        rst = 1'b1;
        #1;
        checkBit("arst_start", out_start[0], 1'b0);
        checkBit("arst_busy", busy[0], 1'b0);
        checkOutput("arst_data", out_data[0], 32'd0);
        checkBit("arst_ovf", overflow[0], 1'b0);
        #2;
        rst = 1'b0;
        exp_q0.delete();
        @(posedge clk);
        #1;
        fill(0, 144, 0, 32'd300);
        checkOutput("refill_first", out_data[0], 32'd301);
        drain(0, 144, 1);
        checkOutput("queue_empty_t4", exp_q0.size(), 32'd0);
        finishFrame(0, "t4");

        // 16-pixel instance: release in FULL without consumption, then a normal frame
        fill(1, 16, 0, 32'd50);
        checkBit("b_start_full", out_start[1], 1'b1);
        applyStimulus(1, 1'b0, 32'd0, 1'b0, 1'b1);
        checkBit("b_busy_released", busy[1], 1'b0);
        checkBit("b_start_released", out_start[1], 1'b0);
        exp_q1.delete();
        fill(1, 16, 0, 32'd60);
        checkBit("b_start_refill", out_start[1], 1'b1);
        drain(1, 16, 1);
        checkOutput("queue_empty_t5", exp_q1.size(), 32'd0);
        finishFrame(1, "t5");
        checkBit("b_ovf_clear", overflow[1], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
